// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a word FIFO and valid/ready input handshake.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_param #(
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          hwclk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          ftdi_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W       = PTR_W + 1;
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [IDX_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]    count_q, count_d;

  logic                 push;
  logic                 pop;
  logic                 empty;
  logic                 bit_end;
  logic                 start_frame;
  logic [DATA_BITS-1:0] head;

  assign tx_ready   = (count_q != FCNT_W'(FIFO_DEPTH));
  assign push       = tx_valid & tx_ready;
  assign empty      = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign bit_end    = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign ftdi_tx    = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  // Frame sequencer: next state, line level and baud/bit counters.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    start_frame = 1'b0;
    pop         = 1'b0;
    baud_d      = (state_q == S_IDLE || bit_end) ? '0 : baud_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty) start_frame = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == IDX_W'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + IDX_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == IDX_W'(STOP_BITS - 1)) begin
            if (!empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Pop the head word straight into the shifter; parity comes from the popped word.
    if (start_frame) begin
      pop     = 1'b1;
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = head;
      par_d   = (PARITY == 1) ? ~(^head) : (^head);
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  // FIFO pointer and occupancy update; push and pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge hwclk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 8N2) at 10 clocks per bit,
// checked every cycle against a frame-level model plus directed literal expectations.
module tb_uart_tx_param;

  localparam int DEPTH = 4;
  localparam int CPB   = 10;
  localparam int PAR_CFG  [4] = '{0, 2, 1, 0};
  localparam int STOP_CFG [4] = '{1, 1, 1, 2};

  logic       hwclk;
  logic       rst;
  logic [7:0] tx_data  [4];
  logic       tx_valid [4];
  logic       rdy      [4];
  logic       line_o   [4];
  logic       busy_o   [4];
  logic [2:0] cnt_o    [4];

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  uart_tx_param #(.CLK_HZ(100), .BAUD(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
    .hwclk(hwclk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(rdy[0]),
    .ftdi_tx(line_o[0]), .busy(busy_o[0]), .fifo_count(cnt_o[0]));
  uart_tx_param #(.CLK_HZ(100), .BAUD(10), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
    .hwclk(hwclk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(rdy[1]),
    .ftdi_tx(line_o[1]), .busy(busy_o[1]), .fifo_count(cnt_o[1]));
  uart_tx_param #(.CLK_HZ(100), .BAUD(10), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o1 (
    .hwclk(hwclk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(rdy[2]),
    .ftdi_tx(line_o[2]), .busy(busy_o[2]), .fifo_count(cnt_o[2]));
  uart_tx_param #(.CLK_HZ(100), .BAUD(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_n2 (
    .hwclk(hwclk), .rst(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]), .tx_ready(rdy[3]),
    .ftdi_tx(line_o[3]), .busy(busy_o[3]), .fifo_count(cnt_o[3]));

  initial begin
    hwclk = 1'b0;
    forever #5 hwclk = ~hwclk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int         m_cnt  [4];
  int         m_head [4];
  int         m_tail [4];
  logic [7:0] m_mem  [4][DEPTH];
  bit         m_act  [4];
  int         m_el   [4];
  int         m_len  [4];
  logic [15:0] m_fb  [4];

  // Bit sequence of a whole frame; unused upper positions stay 1 so stop bits come for free.
  function automatic logic [15:0] build_frame(input int k, input logic [7:0] w);
    logic [15:0] fb;
    fb    = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = w[i];
    if (PAR_CFG[k] == 2) fb[9] = ^w;
    else if (PAR_CFG[k] == 1) fb[9] = ~(^w);
    return fb;
  endfunction

  task automatic model_step();
    bit push;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_cnt[k] = 0; m_head[k] = 0; m_tail[k] = 0; m_act[k] = 0; m_el[k] = 0;
      end else begin
        push = tx_valid[k] && (m_cnt[k] != DEPTH);
        if (m_act[k]) begin
          m_el[k]++;
          if (m_el[k] == m_len[k]) m_act[k] = 0;
        end
        if (!m_act[k] && m_cnt[k] > 0) begin
          m_fb[k]   = build_frame(k, m_mem[k][m_head[k]]);
          m_len[k]  = (1 + 8 + ((PAR_CFG[k] != 0) ? 1 : 0) + STOP_CFG[k]) * CPB;
          m_head[k] = (m_head[k] + 1) % DEPTH;
          m_cnt[k]--;
          m_el[k]   = 0;
          m_act[k]  = 1;
        end
        if (push) begin
          m_mem[k][m_tail[k]] = tx_data[k];
          m_tail[k] = (m_tail[k] + 1) % DEPTH;
          m_cnt[k]++;
        end
      end
    end
  endtask

  function automatic int exp_line(input int k);
    if (!m_act[k]) return 1;
    return int'(m_fb[k][m_el[k] / CPB]);
  endfunction

  initial forever begin
    @(posedge hwclk);
    model_step();
    started = 1;
  end

  // Per-cycle comparison of every instance against the model.
  initial forever begin
    @(negedge hwclk);
    if (started) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("line[%0d]", k),  int'(line_o[k]), exp_line(k));
        chk($sformatf("busy[%0d]", k),  int'(busy_o[k]), int'(m_act[k]));
        chk($sformatf("count[%0d]", k), int'(cnt_o[k]),  m_cnt[k]);
        chk($sformatf("ready[%0d]", k), int'(rdy[k]),    (m_cnt[k] != DEPTH) ? 1 : 0);
      end
    end
  end

  // ---------------- directed stimulus helpers ----------------
  localparam int REC_N = 300;
  logic rec_line [4][REC_N];
  logic rec_busy [4][REC_N];
  logic [7:0] pw [8];
  int acc_edge [8];
  int snap_rdy, snap_cnt;

  // Sample every instance on n consecutive falling edges, starting at the current one.
  task automatic record(input int n);
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge hwclk);
      for (int k = 0; k < 4; k++) begin
        rec_line[k][c] = line_o[k];
        rec_busy[k][c] = busy_o[k];
      end
    end
  endtask

  function automatic int get_line(input int k, input int c);
    if (c < 0 || c >= REC_N) return 1;
    return int'(rec_line[k][c]);
  endfunction

  function automatic int first_busy(input int k);
    for (int c = 0; c < REC_N; c++) if (rec_busy[k][c]) return c;
    return -1;
  endfunction

  function automatic int busy_run(input int k, input int from);
    int n = 0;
    if (from < 0) return 0;
    for (int c = from; c < REC_N && rec_busy[k][c]; c++) n++;
    return n;
  endfunction

  function automatic int ones_run(input int k, input int from);
    int n = 0;
    if (from < 0) return 0;
    for (int c = from; c < REC_N && rec_line[k][c]; c++) n++;
    return n;
  endfunction

  // Producer: offer pw[0..n-1] to instance k, holding each word until accepted.
  task automatic push_words(input int k, input int n);
    int i = 0;
    for (int j = 0; j < 400 && i < n; j++) begin
      tx_valid[k] = 1'b1;
      tx_data[k]  = pw[i];
      if (j == 5) begin snap_rdy = int'(rdy[k]); snap_cnt = int'(cnt_o[k]); end
      if (rdy[k]) begin acc_edge[i] = j; i++; end
      @(negedge hwclk);
    end
    tx_valid[k] = 1'b0;
    chk("push_all_accepted", i, n);
  endtask

  task automatic wait_idle(input int k);
    for (int j = 0; j < 1500 && (busy_o[k] || cnt_o[k] != 0); j++) @(negedge hwclk);
    chk("drain_busy", int'(busy_o[k]), 0);
    chk("drain_count", int'(cnt_o[k]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cs;
    logic [9:0] got;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin tx_valid[k] = 1'b0; tx_data[k] = 8'h00; end

    // Reset held for three edges.
    repeat (3) @(negedge hwclk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_line",  int'(line_o[k]), 1);
      chk("rst_busy",  int'(busy_o[k]), 0);
      chk("rst_ready", int'(rdy[k]),    1);
      chk("rst_count", int'(cnt_o[k]),  0);
    end
    rst = 1'b0;
    repeat (20) @(negedge hwclk);
    chk("idle_line", int'(line_o[0]), 1);
    chk("idle_busy", int'(busy_o[0]), 0);

    // 8N1 0xA5, 8E1 0x07, 8O1 0x07 pushed on the same edge.
    tx_data[0] = 8'hA5; tx_valid[0] = 1'b1;
    tx_data[1] = 8'h07; tx_valid[1] = 1'b1;
    tx_data[2] = 8'h07; tx_valid[2] = 1'b1;
    fork
      record(140);
      begin
        @(negedge hwclk);
        tx_valid[0] = 1'b0; tx_valid[1] = 1'b0; tx_valid[2] = 1'b0;
      end
    join
    cs = first_busy(0);
    chk("a5_start_latency", cs, 2);
    for (int i = 0; i < 10; i++) got[i] = get_line(0, cs + 5 + CPB * i) != 0;
    chk("a5_bits", int'(got), int'(10'b1101001010));
    chk("a5_busy_cycles", busy_run(0, cs), 100);
    chk("a5_low_first_cycle", get_line(0, cs), 0);
    chk("a5_high_before", get_line(0, cs - 1), 1);
    cs = first_busy(1);
    chk("e1_busy_cycles", busy_run(1, cs), 110);
    chk("e1_parity_bit", get_line(1, cs + 95), 1);
    cs = first_busy(2);
    chk("o1_busy_cycles", busy_run(2, cs), 110);
    chk("o1_parity_bit", get_line(2, cs + 95), 0);

    // Six words on consecutive edges into a depth-4 FIFO. w5 completes its handshake on the
    // edge after w1's pop at edge 101, since tx_ready follows the registered count.
    for (int i = 0; i < 6; i++) pw[i] = 8'(8'h10 + i);
    push_words(0, 6);
    chk("q_full_ready", snap_rdy, 0);
    chk("q_full_count", snap_cnt, 4);
    chk("q_acc_w0", acc_edge[0], 0);
    chk("q_acc_w4", acc_edge[4], 4);
    chk("q_acc_w5", acc_edge[5], 102);
    wait_idle(0);

    // 8N2 back-to-back frames: 0x55 (last data bit 0) then 0x3C.
    pw[0] = 8'h55; pw[1] = 8'h3C;
    fork
      push_words(3, 2);
      record(260);
    join
    cs = first_busy(3);
    chk("n2_start_latency", cs, 2);
    chk("n2_busy_two_frames", busy_run(3, cs), 220);
    chk("n2_last_data_bit", get_line(3, cs + 89), 0);
    chk("n2_stop_cycles", ones_run(3, cs + 90), 20);
    chk("n2_next_start", get_line(3, cs + 110), 0);

    // Reset during data bit 3 of a frame with two words queued.
    pw[0] = 8'h81; pw[1] = 8'h42; pw[2] = 8'h24;
    push_words(0, 3);
    repeat (42) @(negedge hwclk);
    chk("mid_count", int'(cnt_o[0]), 2);
    chk("mid_busy", int'(busy_o[0]), 1);
    chk("mid_data_bit3", int'(line_o[0]), 0);
    rst = 1'b1;
    @(negedge hwclk);
    chk("abort_line",  int'(line_o[0]), 1);
    chk("abort_busy",  int'(busy_o[0]), 0);
    chk("abort_count", int'(cnt_o[0]),  0);
    chk("abort_ready", int'(rdy[0]),    1);
    rst = 1'b0;
    repeat (150) @(negedge hwclk);
    chk("post_abort_line",  int'(line_o[0]), 1);
    chk("post_abort_busy",  int'(busy_o[0]), 0);
    chk("post_abort_count", int'(cnt_o[0]),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
